// File: rtl/drop_pkg.sv
// Purpose: shared encodings and sizes for the drop_scheduler game controller.
// Contents: scene encodings, control FSM states, slot geometry and timing constants.
package drop_pkg;

    localparam int unsigned NSLOT       = 12;   // block slots seen by the renderer
    localparam int unsigned PW          = 5;    // row width per slot
    localparam int unsigned IDXW        = 4;    // slot index width
    localparam int unsigned SHW         = 4;    // stack height width
    localparam int unsigned FALL_FRAMES = 4;
    localparam int unsigned ANIM_FRAMES = 8;
    localparam int unsigned FLOOR_ROW   = 24;
    localparam int unsigned STACK_MAX   = 8;

    typedef enum logic [1:0] {
        SC_TITLE = 2'd0,
        SC_PLAY  = 2'd1,
        SC_OVER  = 2'd2
    } scene_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_SPAWN  = 2'd2,
        ST_COMMIT = 2'd3
    } ctl_state_e;

    // Row at which a falling block touches the current stack top.
    function automatic logic [PW-1:0] land_row(input logic [SHW-1:0] stack_h);
        return PW'(FLOOR_ROW - 1) - PW'(stack_h);
    endfunction

endpackage

// File: rtl/drop_scheduler_vs_tick_sync.sv
// Purpose: bring the asynchronous active-low vsync into clk and emit one
// registered pulse per falling edge (3 clk after the edge).
// Ports: clk, rst (sync, active-high), i_vs (async vsync), o_tick (1-clk pulse).
module vs_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_vs,
    output logic o_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Two-stage synchronizer, then a falling-edge detector on the clean copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            o_tick  <= 1'b0;
        end else begin
            r_sync1 <= i_vs;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            o_tick  <= r_prev & ~r_sync2;
        end
    end

endmodule

// File: rtl/drop_scheduler.sv
// Purpose: game-side sequencer for the VGA renderer. Once per frame it walks the
// 12 block slots on a shadow copy (falls, landings, free-slot search), services
// one pending drop request, then publishes a consistent snapshot at COMMIT.
// Ports: clk, rst (sync, active-high), i_vs (async vsync), i_start, i_drop_req,
//        o_blocks, o_pos_blocks, o_scene, o_people, o_stack_h, o_drop_miss.
module drop_scheduler
    import drop_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vs,
    input  logic                  i_start,
    input  logic                  i_drop_req,
    output logic [NSLOT-1:0]      o_blocks,
    output logic [NSLOT*PW-1:0]   o_pos_blocks,
    output logic [1:0]            o_scene,
    output logic [1:0]            o_people,
    output logic [SHW-1:0]        o_stack_h,
    output logic                  o_drop_miss
);

    localparam int unsigned FCW = $clog2(FALL_FRAMES);
    localparam int unsigned ACW = $clog2(ANIM_FRAMES);

    logic                       w_frame_tick;
    ctl_state_e                 r_state;
    logic [IDXW-1:0]            r_idx;
    logic [NSLOT-1:0]           r_sh_valid;
    logic [NSLOT-1:0][PW-1:0]   r_sh_pos;
    logic [SHW-1:0]             r_sh_stack;
    logic                       r_pending;
    logic                       r_start_seen;
    logic [FCW-1:0]             r_fall_cnt;
    logic [ACW-1:0]             r_anim_cnt;
    logic                       r_fall_step;
    logic                       r_anim_step;
    logic                       r_free_ok;
    logic [IDXW-1:0]            r_free_idx;

    logic                       w_cur_valid;
    logic [PW-1:0]              w_cur_pos;
    logic                       w_do_fall;
    logic                       w_lands;
    logic                       w_cur_free;

    vs_tick_sync u_vs_tick_sync (
        .clk    (clk),
        .rst    (rst),
        .i_vs   (i_vs),
        .o_tick (w_frame_tick)
    );

    // Per-slot decision for the slot currently being scanned.
    assign w_cur_valid = r_sh_valid[r_idx];
    assign w_cur_pos   = r_sh_pos[r_idx];
    assign w_do_fall   = (o_scene == SC_PLAY) && r_fall_step;
    assign w_lands     = w_do_fall && w_cur_valid && (w_cur_pos >= land_row(r_sh_stack));
    assign w_cur_free  = !w_cur_valid || w_lands;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_sh_valid   <= '0;
            r_sh_pos     <= '0;
            r_sh_stack   <= '0;
            r_pending    <= 1'b0;
            r_start_seen <= 1'b0;
            r_fall_cnt   <= '0;
            r_anim_cnt   <= '0;
            r_fall_step  <= 1'b0;
            r_anim_step  <= 1'b0;
            r_free_ok    <= 1'b0;
            r_free_idx   <= '0;
            o_blocks     <= '0;
            o_pos_blocks <= '0;
            o_scene      <= SC_TITLE;
            o_people     <= '0;
            o_stack_h    <= '0;
            o_drop_miss  <= 1'b0;
        end else begin
            o_drop_miss <= 1'b0;

            // start is remembered until the next COMMIT; a pulse in the COMMIT cycle survives.
            r_start_seen <= i_start | (r_start_seen & (r_state != ST_COMMIT));

            // A request in the SPAWN cycle re-arms pending for the next frame.
            if (i_drop_req && (o_scene == SC_PLAY)) begin
                r_pending <= 1'b1;
            end else if (r_state == ST_SPAWN) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_frame_tick) begin
                        r_state     <= ST_SCAN;
                        r_idx       <= '0;
                        r_free_ok   <= 1'b0;
                        r_free_idx  <= '0;
                        r_fall_cnt  <= (r_fall_cnt == FCW'(FALL_FRAMES - 1)) ? '0 : r_fall_cnt + FCW'(1);
                        r_fall_step <= (r_fall_cnt == FCW'(FALL_FRAMES - 1));
                        r_anim_cnt  <= (r_anim_cnt == ACW'(ANIM_FRAMES - 1)) ? '0 : r_anim_cnt + ACW'(1);
                        r_anim_step <= (r_anim_cnt == ACW'(ANIM_FRAMES - 1));
                    end
                end
                ST_SCAN: begin
                    // Landings update the stack immediately, so later slots see the new top.
                    if (w_do_fall && w_cur_valid) begin
                        if (w_lands) begin
                            r_sh_valid[r_idx] <= 1'b0;
                            if (r_sh_stack != '1) begin
                                r_sh_stack <= r_sh_stack + SHW'(1);
                            end
                        end else begin
                            r_sh_pos[r_idx] <= w_cur_pos + PW'(1);
                        end
                    end
                    if (w_cur_free && !r_free_ok) begin
                        r_free_ok  <= 1'b1;
                        r_free_idx <= r_idx;
                    end
                    if (r_idx == IDXW'(NSLOT - 1)) begin
                        r_state <= ST_SPAWN;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                ST_SPAWN: begin
                    if (r_pending && (o_scene == SC_PLAY)) begin
                        if (r_free_ok) begin
                            r_sh_valid[r_free_idx] <= 1'b1;
                            r_sh_pos[r_free_idx]   <= '0;
                        end else begin
                            o_drop_miss <= 1'b1;
                        end
                    end
                    r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_state      <= ST_IDLE;
                    o_blocks     <= r_sh_valid;
                    o_pos_blocks <= r_sh_pos;
                    o_stack_h    <= r_sh_stack;
                    if (r_anim_step && (o_scene == SC_PLAY)) begin
                        o_people <= o_people + 2'd1;
                    end
                    case (o_scene)
                        SC_TITLE: begin
                            if (r_start_seen) begin
                                // Fresh game: playfield starts empty in the same snapshot.
                                o_scene      <= SC_PLAY;
                                r_sh_valid   <= '0;
                                r_sh_pos     <= '0;
                                r_sh_stack   <= '0;
                                o_blocks     <= '0;
                                o_pos_blocks <= '0;
                                o_stack_h    <= '0;
                            end
                        end
                        SC_PLAY: begin
                            if (r_sh_stack >= SHW'(STACK_MAX)) begin
                                o_scene <= SC_OVER;
                            end
                        end
                        SC_OVER: begin
                            if (r_start_seen) begin
                                o_scene <= SC_TITLE;
                            end
                        end
                        default: o_scene <= SC_TITLE;
                    endcase
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler: vsync-framed stimulus with hand-computed
// expectations for scene flow, falls, landings, spawns, misses and reset.
module tb_drop_scheduler;

    logic        clk;
    logic        rst;
    logic        i_vs;
    logic        i_start;
    logic        i_drop_req;
    logic [11:0] o_blocks;
    logic [59:0] o_pos_blocks;
    logic [1:0]  o_scene;
    logic [1:0]  o_people;
    logic [3:0]  o_stack_h;
    logic        o_drop_miss;

    int checks = 0;
    int errors = 0;
    int miss_cnt;
    int miss_sum;
    int k;
    logic [1:0]  scene_e17;
    logic [1:0]  scene_e18;
    logic [59:0] exp_pos;

    drop_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .i_vs         (i_vs),
        .i_start      (i_start),
        .i_drop_req   (i_drop_req),
        .o_blocks     (o_blocks),
        .o_pos_blocks (o_pos_blocks),
        .o_scene      (o_scene),
        .o_people     (o_people),
        .o_stack_h    (o_stack_h),
        .o_drop_miss  (o_drop_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One video frame: vsync low for 20 clk, high for 4 clk. Edge c=1 is the
    // first posedge after the falling edge; COMMIT lands on edge 18.
    task automatic frame();
        @(negedge clk);
        i_vs = 1'b0;
        miss_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (o_drop_miss) miss_cnt++;
            if (c == 17) scene_e17 = o_scene;
            if (c == 18) scene_e18 = o_scene;
        end
        @(negedge clk);
        i_vs = 1'b1;
        repeat (4) @(posedge clk);
        k++;
    endtask

    task automatic frames_until(input int target);
        while (k < target) begin
            frame();
            miss_sum += miss_cnt;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
    endtask

    task automatic pulse_drop();
        @(negedge clk) i_drop_req = 1'b1;
        @(negedge clk) i_drop_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_vs = 1'b1;
        i_start = 1'b0;
        i_drop_req = 1'b0;
        k = 0;
        miss_sum = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_blocks", 64'(o_blocks), 64'h0);
        chk("rst_pos", 64'(o_pos_blocks), 64'h0);
        chk("rst_scene", 64'(o_scene), 64'h0);
        chk("rst_people", 64'(o_people), 64'h0);
        chk("rst_stack", 64'(o_stack_h), 64'h0);
        chk("rst_miss", 64'(o_drop_miss), 64'h0);
        @(negedge clk) rst = 1'b0;

        // Idle title frames.
        frames_until(3);
        chk("title_scene", 64'(o_scene), 64'h0);
        chk("title_blocks", 64'(o_blocks), 64'h0);

        // start -> PLAY exactly at edge 18 of the frame.
        pulse_start();
        frame();
        chk("lat_before", 64'(scene_e17), 64'h0);
        chk("lat_after", 64'(scene_e18), 64'h1);
        chk("play_blocks", 64'(o_blocks), 64'h0);

        // First block spawns in slot 0 at row 0 (k=5).
        pulse_drop();
        frame();
        chk("spawn_blocks", 64'(o_blocks), 64'h001);
        chk("spawn_pos", 64'(o_pos_blocks[4:0]), 64'h0);
        frames_until(7);
        chk("pos_k7", 64'(o_pos_blocks[4:0]), 64'h0);
        frames_until(8);
        chk("pos_k8", 64'(o_pos_blocks[4:0]), 64'h1);
        chk("people_k8", 64'(o_people), 64'h1);
        frames_until(12);
        chk("pos_k12", 64'(o_pos_blocks[4:0]), 64'h2);

        // Falls every 4th frame: row 23 at k=96, lands on the floor at k=100.
        frames_until(99);
        chk("pre_land_blocks", 64'(o_blocks), 64'h001);
        chk("pre_land_pos", 64'(o_pos_blocks[4:0]), 64'd23);
        chk("pre_land_stack", 64'(o_stack_h), 64'h0);
        frames_until(100);
        chk("land_blocks", 64'(o_blocks), 64'h000);
        chk("land_stack", 64'(o_stack_h), 64'h1);

        // Fill all 12 slots over frames 101..112.
        miss_sum = 0;
        pulse_drop();
        frame();
        miss_sum += miss_cnt;
        chk("fill_first", 64'(o_blocks), 64'h001);
        for (int j = 1; j < 12; j++) begin
            pulse_drop();
            frame();
            miss_sum += miss_cnt;
        end
        chk("fill_full", 64'(o_blocks), 64'hFFF);
        chk("fill_no_miss", 64'(miss_sum), 64'h0);

        // 13th request: no free slot.
        pulse_drop();
        frame();
        chk("miss_pulse", 64'(miss_cnt), 64'h1);
        chk("miss_blocks", 64'(o_blocks), 64'hFFF);

        // Slots 0-2 fall first, 3-6 one row behind, 7-10 two, slot 11 three.
        for (int i = 0; i < 12; i++) begin
            exp_pos[i*5 +: 5] = (i < 3) ? 5'd22 : (i < 7) ? 5'd21 : (i < 11) ? 5'd20 : 5'd19;
        end
        frames_until(188);
        chk("k188_blocks", 64'(o_blocks), 64'hFFF);
        chk("k188_pos", 64'(o_pos_blocks), 64'(exp_pos));
        chk("k188_stack", 64'(o_stack_h), 64'h1);
        chk("k188_people", 64'(o_people), 64'h3);
        chk("k188_scene", 64'(o_scene), 64'h1);

        // All 12 land in one scan, each on the already-raised stack.
        frames_until(192);
        chk("k192_blocks", 64'(o_blocks), 64'h000);
        chk("k192_stack", 64'(o_stack_h), 64'd13);
        chk("k192_scene", 64'(o_scene), 64'h2);
        chk("k192_people", 64'(o_people), 64'h0);
        chk("k192_pos", 64'(o_pos_blocks), 64'(exp_pos));

        // Game over: frozen, drop requests ignored.
        miss_sum = 0;
        pulse_drop();
        frames_until(200);
        chk("over_blocks", 64'(o_blocks), 64'h000);
        chk("over_pos", 64'(o_pos_blocks), 64'(exp_pos));
        chk("over_scene", 64'(o_scene), 64'h2);
        chk("over_people", 64'(o_people), 64'h0);
        chk("over_no_miss", 64'(miss_sum), 64'h0);

        pulse_start();
        frame();
        chk("back_title", 64'(o_scene), 64'h0);
        chk("back_stack", 64'(o_stack_h), 64'd13);

        // Reset while the scan is at slot 6 (edge 11 of the frame).
        @(negedge clk);
        i_vs = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_blocks", 64'(o_blocks), 64'h0);
        chk("mid_rst_pos", 64'(o_pos_blocks), 64'h0);
        chk("mid_rst_stack", 64'(o_stack_h), 64'h0);
        chk("mid_rst_scene", 64'(o_scene), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        i_vs = 1'b1;
        repeat (4) @(posedge clk);
        frame();
        chk("post_rst_scene", 64'(o_scene), 64'h0);
        chk("post_rst_blocks", 64'(o_blocks), 64'h0);
        chk("post_rst_pos", 64'(o_pos_blocks), 64'h0);
        chk("post_rst_stack", 64'(o_stack_h), 64'h0);
        chk("post_rst_people", 64'(o_people), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/drop_scheduler.md
Name: drop_scheduler

Overview:
- Game-side controller that sequences the VGA renderer `print_out`.
- Owns the scene state machine, the 12 falling-block slots, the landed-stack height and the person animation frame.
- Publishes a new, consistent `blocks`/`pos_blocks`/`scene`/`people` snapshot once per video frame, during vertical sync, so the renderer never draws a half-updated frame.
- Sits between the input/button logic and `print_out`.

Parameters:
- NSLOT, 12, number of block slots (fixed by the renderer interface).
- PW, 5, position width per slot, in rows 0..31.
- FALL_FRAMES, 4, frames between one-row fall steps.
- FLOOR_ROW, 24, row of the empty floor.
- STACK_MAX, 8, stack height that ends the game.
- ANIM_FRAMES, 8, frames per `people` animation step.

Ports:
- clk  in  1  system clock (same `clk` that drives `print_out`).
- rst  in  1  synchronous, active-high reset.
- vs  in  1  vertical sync from `print_out`, asynchronous to clk, active-low pulse.
- start  in  1  single-cycle pulse: TITLE->PLAY, OVER->TITLE.
- drop_req  in  1  single-cycle pulse requesting a new block.
- blocks  out  12  slot valid mask, bit i = slot i active.
- pos_blocks  out  60  slot i row = pos_blocks[5i+4:5i].
- scene  out  2  0=TITLE, 1=PLAY, 2=OVER.
- people  out  2  animation frame index.
- stack_h  out  4  landed-block count.
- drop_miss  out  1  one-cycle pulse: request discarded, no free slot.

Behaviour:
- Reset (synchronous, active-high) clears every output and internal register:
  - blocks=0, pos_blocks=0, scene=0, people=0, stack_h=0, drop_miss=0.
  - Control FSM returns to IDLE; pending flag and frame counters cleared.
  - Reset asserted mid-scan aborts the scan; nothing is committed.
- Frame tick:
  - vs passes through a 2-FF synchronizer, then a falling-edge detector.
  - frame_tick pulses 3 clk after the vs falling edge.
  - Exactly one tick per frame.
- drop_req handling:
  - Any drop_req sets `pending`.
  - Multiple requests before service collapse to one.
  - drop_req is ignored outside PLAY.
- Control FSM states are IDLE, SCAN, SPAWN, COMMIT.
  - IDLE: on frame_tick, go to SCAN with idx=0. Frame counters advance here (fall_cnt mod FALL_FRAMES, anim_cnt mod ANIM_FRAMES).
  - SCAN: one slot per clk, idx 0..11, 12 cycles. Works on a shadow copy (shadow valid/pos).
    - Only when scene=PLAY and fall_cnt wraps to 0: an active slot with pos < FLOOR_ROW-1-stack_h increments pos.
    - Otherwise (pos ≥ FLOOR_ROW-1-stack_h, i.e. the block touches the stack) it lands: slot freed, stack_h+1.
    - Several landings in one scan each add 1, processed in idx order.
    - Each landing uses the already-updated stack_h.
    - stack_h saturates at 15.
    - Records the lowest free slot index (after landings).
  - SPAWN (1 clk): if pending and a free slot exists, that slot becomes valid with pos 0. If pending and no slot is free, drop_miss pulses. pending clears in both cases. A drop_req arriving in the same cycle re-sets pending (new request wins).
  - COMMIT (1 clk): copy shadow to blocks/pos_blocks, update scene and people, go to IDLE.
    - Total tick-to-output latency = 1+12+1+1 = 15 clk. Outputs are stable at all other times.
    - frame_tick arriving while not in IDLE is dropped. It cannot occur at VGA rates, but must not corrupt state.
- Scene FSM, evaluated at COMMIT:
  - TITLE + start_seen -> PLAY, with shadow valid, pos and stack_h all cleared in that same commit.
  - PLAY + stack_h ≥ STACK_MAX -> OVER. Blocks freeze; no falls or spawns in OVER.
  - OVER + start_seen -> TITLE.
  - `start` is latched into start_seen whenever it pulses and consumed at COMMIT.
- people: increments mod 4 at each COMMIT where anim_cnt wrapped; PLAY only; held otherwise.

Decomposition:
- Package drop_pkg: scene encodings (SC_TITLE/SC_PLAY/SC_OVER), NSLOT, PW, FSM state enum, slot index width (4).
- One sub-module, vs_tick_sync: 2-FF synchronizer plus falling-edge pulse generator, reusable by other frame-locked blocks.

Test Plan:
- Reset, then 3 frames of vs -> all outputs 0, scene=0. One COMMIT per frame, 15 clk after each vs falling edge.
- start, 1 frame, drop_req, 1 frame -> scene=1, blocks=12'h001, pos_blocks[4:0]=0. Pos increments every 4th frame: 0,1,2...
- Single block, no stack -> lands after 23 fall steps (92 frames). blocks returns to 0, stack_h=1. The next block lands one row higher (22 steps).
- Fill all 12 slots with 12 drop_req across 12 frames, then a 13th drop_req -> drop_miss single pulse, blocks=12'hFFF unchanged.
- 8 landings -> scene=2 at that COMMIT; further drop_req and frames leave blocks/pos unchanged. start -> scene=0 next frame.
- rst asserted during SCAN (idx=6) -> next-cycle outputs all 0; the following frame commits a clean TITLE state.
